// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDU_* operation codes (4-bit), common to the decoder, the D->E register
//     and the MDU itself.
//   - Default busy-cycle counts for multiply and divide.
//   - FSM state type, exposed by mdu_core for observation.
//   - Small decode helpers.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    // True for the four multi-cycle operations that may be launched by start.
    function automatic logic mdu_is_launch(input logic [3:0] ctr);
        return (ctr == MDU_MULT) || (ctr == MDU_MULTU) ||
               (ctr == MDU_DIV)  || (ctr == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] ctr);
        return (ctr == MDU_DIV) || (ctr == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> MDU signal bundle.
//   start    : launch pulse for mult/multu/div/divu
//   mdu_ctr  : operation code (mdu_pkg::MDU_*)
//   rs_val   : forwarded rs operand
//   rt_val   : forwarded rt operand
//   busy     : multi-cycle operation in flight
//   hi, lo   : architectural HI/LO
//   md_out   : mfhi/mflo read data (combinational)
//
// Handshake: start acts as a one-cycle valid and !busy as ready. The hazard
// unit only presents start (or an MTHI/MTLO) in a cycle where busy is low;
// a transfer happens on the rising edge where start=1 and busy=0. While busy
// is high, start and MTHI/MTLO must stay deasserted.
interface mdu_if;
    logic        start;
    logic [3:0]  mdu_ctr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output start, mdu_ctr, rs_val, rt_val,
        input  busy, hi, lo, md_out
    );

    modport slave (
        input  start, mdu_ctr, rs_val, rt_val,
        output busy, hi, lo, md_out
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
//   op      in  4   operation code (MULT/MULTU/DIV/DIVU, others give 0)
//   a       in  32  rs operand (multiplicand / dividend)
//   b       in  32  rt operand (multiplier / divisor)
//   res_hi  out 32  product high word / remainder
//   res_lo  out 32  product low word / quotient
//   valid   out 1   result should be committed (low for divide by zero)
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        valid
);

    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        safe_b;
    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (op == MDU_DIV) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Replacing the divisor by 1 in the two special cases keeps the divider
    // away from undefined inputs; for 0x80000000/-1 it also yields the
    // required quotient 0x80000000 and remainder 0 directly.
    assign safe_b = (div_zero || div_ovf) ? 32'd1 : b;

    assign a_sx   = $signed({{32{a[31]}}, a});
    assign b_sx   = $signed({{32{b[31]}}, b});
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Verilog signed / and % truncate toward zero; remainder takes the
    // dividend's sign.
    assign quo_s = $signed(a) / $signed(safe_b);
    assign rem_s = $signed(a) % $signed(safe_b);
    assign quo_u = a / safe_b;
    assign rem_u = a % safe_b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        valid  = 1'b0;
        case (op)
            MDU_MULT: begin
                {res_hi, res_lo} = prod_s;
                valid = 1'b1;
            end
            MDU_MULTU: begin
                {res_hi, res_lo} = prod_u;
                valid = 1'b1;
            end
            MDU_DIV: begin
                res_lo = quo_s;
                res_hi = rem_s;
                valid  = !div_zero;
            end
            MDU_DIVU: begin
                res_lo = quo_u;
                res_hi = rem_u;
                valid  = !div_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_core.sv
// Multiply/divide unit for the E stage: counter FSM, pending result
// registers and the architectural HI/LO.
//   clk        in   clock
//   reset      in   synchronous, active-high
//   bus        slave modport of mdu_if (start/mdu_ctr/rs_val/rt_val in,
//              busy/hi/lo/md_out out)
//   state_dbg  out  current FSM state (IDLE when the counter is zero)
module mdu_core
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mdu_if.slave       bus,
    output mdu_state_e state_dbg
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_valid;
    mdu_state_e       state;

    mdu_arith u_arith (
        .op     (bus.mdu_ctr),
        .a      (bus.rs_val),
        .b      (bus.rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .valid  (res_valid)
    );

    // The counter is the state: zero means IDLE, anything else means RUN.
    assign state     = (cnt_q != '0) ? MDU_RUN : MDU_IDLE;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            pend_hi_q    <= 32'd0;
            pend_lo_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        case (state)
            MDU_IDLE: begin
                if (bus.start && mdu_is_launch(bus.mdu_ctr)) begin
                    pend_hi_d    = res_hi;
                    pend_lo_d    = res_lo;
                    pend_valid_d = res_valid;
                    cnt_d        = mdu_is_div(bus.mdu_ctr) ? CNT_W'(DIV_CYCLES)
                                                           : CNT_W'(MULT_CYCLES);
                end else if (bus.mdu_ctr == MDU_MTHI) begin
                    hi_d = bus.rs_val;
                end else if (bus.mdu_ctr == MDU_MTLO) begin
                    lo_d = bus.rs_val;
                end
            end
            MDU_RUN: begin
                // start and MTHI/MTLO are ignored here, so the commit edge
                // always wins over either.
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d = '0;
                    if (pend_valid_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        case (bus.mdu_ctr)
            MDU_MFHI: bus.md_out = hi_q;
            MDU_MFLO: bus.md_out = lo_q;
            default:  bus.md_out = 32'd0;
        endcase
    end

    assign bus.busy = (state == MDU_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Hazard-unit guarantees.
    a_no_start_busy : assert property (@(posedge clk) disable iff (reset)
        bus.start |-> !bus.busy);
    a_start_legal   : assert property (@(posedge clk) disable iff (reset)
        bus.start |-> mdu_is_launch(bus.mdu_ctr));
    a_no_mt_busy    : assert property (@(posedge clk) disable iff (reset)
        ((bus.mdu_ctr == MDU_MTHI) || (bus.mdu_ctr == MDU_MTLO)) |-> !bus.busy);

endmodule

// File: tb/tb_mdu_core.sv
module tb_mdu_core;
    import mdu_pkg::*;

    logic       clk;
    logic       reset;
    mdu_state_e state_dbg;
    int         tests;
    int         failed;

    mdu_if bus ();

    mdu_core #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / reset: inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a launch for one edge, then return to NONE. Returns in the
    // first busy cycle (T0+1).
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.mdu_ctr = op;
        bus.rs_val  = a;
        bus.rt_val  = b;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.mdu_ctr = MDU_NONE;
    endtask

    // Expect busy for n cycles with old HI/LO held, then the new values.
    task automatic run_check(input string tag, input int n,
                             input logic [31:0] old_hi, input logic [31:0] old_lo,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        for (int i = 1; i <= n; i++) begin
            check({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
            if (i == n) begin
                check({tag, ".hold_hi"}, bus.hi, old_hi);
                check({tag, ".hold_lo"}, bus.lo, old_lo);
            end
            @(negedge clk);
        end
        check({tag, ".done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, ".hi"}, bus.hi, exp_hi);
        check({tag, ".lo"}, bus.lo, exp_lo);
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        bus.mdu_ctr = op;
        bus.rs_val  = val;
        @(negedge clk);
        bus.mdu_ctr = MDU_NONE;
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.mdu_ctr = MDU_NONE;
        bus.rs_val  = 32'd0;
        bus.rt_val  = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.hi", bus.hi, 32'd0);
        check("rst.lo", bus.lo, 32'd0);
        check("rst.md_out", bus.md_out, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // MTHI in idle, then MFHI / MFLO / unused code on md_out
        move_to(MDU_MTHI, 32'h0000_1234);
        check("mthi.hi", bus.hi, 32'h0000_1234);
        check("mthi.busy", {31'd0, bus.busy}, 32'd0);
        check("mthi.lo", bus.lo, 32'd0);
        bus.mdu_ctr = MDU_MFHI;
        #1 check("mfhi.md_out", bus.md_out, 32'h0000_1234);
        bus.mdu_ctr = MDU_MFLO;
        #1 check("mflo.md_out", bus.md_out, 32'd0);
        bus.mdu_ctr = 4'd12;
        #1 check("ctr12.md_out", bus.md_out, 32'd0);
        bus.mdu_ctr = MDU_NONE;
        @(negedge clk);

        // MULT -3 * 7 = -21
        launch(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        run_check("mult", 5, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_check("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0001);

        // DIV -7 / 2 = -3 rem -1
        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_check("div", 10, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIV 7 / -2 = -3 rem 1
        launch(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
        run_check("div_negdiv", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFD);

        // DIVU 100 / 7 = 14 rem 2
        launch(MDU_DIVU, 32'd100, 32'd7);
        run_check("divu", 10, 32'h0000_0001, 32'hFFFF_FFFD, 32'h0000_0002, 32'h0000_000E);

        // DIVU by zero leaves preloaded HI/LO
        move_to(MDU_MTHI, 32'h0000_0011);
        move_to(MDU_MTLO, 32'h0000_0022);
        check("pre.hi", bus.hi, 32'h0000_0011);
        check("pre.lo", bus.lo, 32'h0000_0022);
        launch(MDU_DIVU, 32'd7, 32'd0);
        run_check("divu0", 10, 32'h0000_0011, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022);

        // Signed overflow 0x80000000 / -1
        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("div_ovf", 10, 32'h0000_0011, 32'h0000_0022, 32'h0000_0000, 32'h8000_0000);

        // MULT 3 * 5 so HI/LO are nonzero before the reset test
        launch(MDU_MULT, 32'd3, 32'd5);
        run_check("mult_pos", 5, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_000F);
        bus.mdu_ctr = MDU_MFLO;
        #1 check("mflo2.md_out", bus.md_out, 32'h0000_000F);
        bus.mdu_ctr = MDU_NONE;
        @(negedge clk);

        // Reset at busy cycle 3 of a MULT aborts it
        launch(MDU_MULT, 32'd6, 32'd7);
        @(negedge clk);
        @(negedge clk);
        check("abort.busy3", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", {31'd0, bus.busy}, 32'd0);
        check("abort.hi", bus.hi, 32'd0);
        check("abort.lo", bus.lo, 32'd0);
        repeat (6) @(negedge clk);
        check("abort.late_busy", {31'd0, bus.busy}, 32'd0);
        check("abort.late_hi", bus.hi, 32'd0);
        check("abort.late_lo", bus.lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
